// File: rtl/clk_sched_pkg.sv
// Shared types and helpers for the clock-enable scheduler.
package clk_sched_pkg;

  localparam int DEF_DIV_W = 16;

  typedef logic [DEF_DIV_W-1:0] div_t;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_sched_chan.sv
// One tick channel: programmable divider with a shadow ratio that is
// applied only on the period boundary.
module clk_sched_chan
  import clk_sched_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  output logic             tick,
  output logic             sq,
  output logic             pending
);

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt_r, div_r, shadow_r;
  logic [DIV_W-1:0] cnt_s, div_s, shadow_s;
  logic             pending_r, tick_r, sq_r;
  logic             pending_s, tick_s, sq_s;
  logic             active_s, wrap_s, wr_direct_s, wr_shadow_s;

  // Next-state for counter, ratio, shadow and outputs.
  always_comb begin
    active_s    = run && (div_r != DIV_ZERO);
    wrap_s      = active_s && (cnt_r == (div_r - DIV_ONE));
    // A disabled channel or a write landing on the wrap edge takes the ratio at once.
    wr_direct_s = wr_en && ((div_r == DIV_ZERO) || wrap_s);
    wr_shadow_s = wr_en && !wr_direct_s;

    tick_s    = wrap_s;
    sq_s      = wrap_s ? !sq_r : sq_r;
    shadow_s  = wr_shadow_s ? wr_div : shadow_r;
    pending_s = wr_shadow_s ? 1'b1 : (wrap_s ? 1'b0 : pending_r);
    div_s     = wr_direct_s ? wr_div : ((wrap_s && pending_r) ? shadow_r : div_r);
    cnt_s     = (wr_direct_s || wrap_s) ? DIV_ZERO :
                (active_s ? (cnt_r + DIV_ONE) : cnt_r);
  end

  // Channel state registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= DIV_ZERO;
      div_r     <= DIV_RST;
      shadow_r  <= DIV_ZERO;
      pending_r <= 1'b0;
      tick_r    <= 1'b0;
      sq_r      <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      div_r     <= div_s;
      shadow_r  <= shadow_s;
      pending_r <= pending_s;
      tick_r    <= tick_s;
      sq_r      <= sq_s;
    end
  end

  assign tick    = tick_r;
  assign sq      = sq_r;
  assign pending = pending_r;

endmodule

// File: rtl/clk_en_sched.sv
// Multi-channel clock-enable scheduler: config decode, ready mux, error
// flag and one divider channel per tick output.
module clk_en_sched
  import clk_sched_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  DIV_W       = DEF_DIV_W,
  parameter int  DEFAULT_DIV = 2,
  localparam int CH_W        = ch_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  logic [NUM_CH-1:0] wr_en_s;
  logic              cfg_ready_s;
  logic              in_range_s;
  logic              cfg_err_r;

  // Channel decode; out-of-range selects are always ready so they can be dropped.
  always_comb begin
    cfg_ready_s = 1'b1;
    in_range_s  = 1'b0;
    wr_en_s     = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_ch == CH_W'(c)) begin
        in_range_s  = 1'b1;
        cfg_ready_s = !pending[c];
        wr_en_s[c]  = cfg_valid && !pending[c];
      end else begin
        wr_en_s[c]  = 1'b0;
      end
    end
  end

  // Error pulse for an accepted write to a non-existent channel.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_valid && !in_range_s;
    end
  end

  assign cfg_ready = cfg_ready_s;
  assign cfg_err   = cfg_err_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_sched_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .run     (run),
      .wr_en   (wr_en_s[g]),
      .wr_div  (cfg_div),
      .tick    (tick[g]),
      .sq      (sq[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_en_sched.sv
// Self-checking bench: countdown-based reference model compared every cycle,
// directed scenarios with hand-computed timing, then randomized traffic.
module tb_clk_en_sched;

  // Five channels so that a 3-bit cfg_ch can address channel 5 (out of range).
  localparam int NUM_CH = 5;
  localparam int DIV_W  = 16;
  localparam int DEF    = 2;
  localparam int CH_W   = 3;

  logic              clk_in = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b1;
  logic              cfg_valid = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              cfg_ready;
  logic              cfg_err;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: ratio, edges remaining until the next tick, shadow.
  int m_div[NUM_CH];
  int m_rem[NUM_CH];
  int m_shadow[NUM_CH];
  bit m_pend[NUM_CH];
  bit m_sq[NUM_CH];
  bit m_tick[NUM_CH];
  bit m_err;

  logic [NUM_CH-1:0] et, es, ep;

  always #5 clk_in = ~clk_in;

  clk_en_sched #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .pending   (pending),
    .tick      (tick),
    .sq        (sq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_ready(input int ch);
    return (ch >= NUM_CH) ? 1'b1 : !m_pend[ch];
  endfunction

  task automatic model_step();
    int ch;
    int d_in;
    bit acc;
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_div[c] = DEF; m_rem[c] = DEF; m_shadow[c] = 0;
        m_pend[c] = 1'b0; m_sq[c] = 1'b0; m_tick[c] = 1'b0;
      end
      m_err = 1'b0;
      return;
    end
    ch   = int'(cfg_ch);
    d_in = int'(cfg_div);
    acc  = cfg_valid && m_ready(ch);
    m_err = acc && (ch >= NUM_CH);
    for (int c = 0; c < NUM_CH; c++) begin
      bit dis;
      bit wrap;
      dis  = (m_div[c] == 0);
      wrap = run && !dis && (m_rem[c] == 1);
      m_tick[c] = wrap;
      if (wrap) begin
        m_sq[c] = !m_sq[c];
        if (m_pend[c]) begin
          m_div[c] = m_shadow[c];
          m_pend[c] = 1'b0;
        end
        m_rem[c] = m_div[c];
      end else if (run && !dis) begin
        m_rem[c] = m_rem[c] - 1;
      end
      if (acc && ch == c) begin
        if (dis || wrap) begin
          m_div[c] = d_in;
          m_rem[c] = d_in;
        end else begin
          m_shadow[c] = d_in;
          m_pend[c] = 1'b1;
        end
      end
    end
  endtask

  // Advance the model on every edge and compare all outputs shortly after.
  always @(posedge clk_in) begin
    model_step();
    cyc++;
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      et[c] = m_tick[c];
      es[c] = m_sq[c];
      ep[c] = m_pend[c];
    end
    chk("tick", tick, et);
    chk("sq", sq, es);
    chk("pending", pending, ep);
    chk("cfg_err", cfg_err, m_err);
    chk("cfg_ready", cfg_ready, m_ready(int'(cfg_ch)));
  end

  task automatic wait_tick(input int c, output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_in);
      #2;
      if (tick[c]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk($sformatf("timeout_ch%0d", c), 32'd0, 32'd1);
  endtask

  // Four edges after reset release with DEFAULT_DIV=2 on every channel.
  task automatic reset_pattern(input string name);
    logic [NUM_CH-1:0] ones;
    ones = '1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk_in);
      #2;
      chk({name, "_tick"}, tick, (i % 2 == 0) ? ones : '0);
      chk({name, "_sq"}, sq, (i == 2 || i == 3) ? ones : '0);
      chk({name, "_pend"}, pending, '0);
    end
  endtask

  initial begin
    int t, t2, t3, acc, r, nt;
    logic sq_hold;

    #300000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, t2, t3, acc, r, nt;
    logic sq_hold;

    // Test 1: reset values and default timing
    repeat (3) @(posedge clk_in);
    #3;
    chk("rst_tick", tick, '0);
    chk("rst_sq", sq, '0);
    chk("rst_pend", pending, '0);
    chk("rst_err", cfg_err, 1'b0);
    @(negedge clk_in) rst_n = 1'b1;
    reset_pattern("t1");

    // Test 2: ch1 at cnt=0, new ratio 5 waits for the boundary
    @(negedge clk_in);
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd5;
    @(posedge clk_in);
    acc = cyc;
    #2;
    chk("t2_pend_set", pending[1], 1'b1);
    @(negedge clk_in);
    cfg_valid = 1'b0;
    #1;
    chk("t2_ready_low", cfg_ready, 1'b0);
    wait_tick(1, t);
    chk("t2_old_wrap", t - acc, 32'd1);
    chk("t2_pend_clr", pending[1], 1'b0);
    wait_tick(1, t2);
    chk("t2_gap1", t2 - t, 32'd5);
    wait_tick(1, t3);
    chk("t2_gap2", t3 - t2, 32'd5);

    // Test 3: disable ch2, then re-enable with ratio 3
    wait_tick(2, t);
    @(negedge clk_in);
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd0;
    @(posedge clk_in);
    acc = cyc;
    #2;
    chk("t3_pend_set", pending[2], 1'b1);
    cfg_valid = 1'b0;
    wait_tick(2, t);
    chk("t3_last_tick", t - acc, 32'd1);
    sq_hold = sq[2];
    nt = 0;
    repeat (10) begin
      @(posedge clk_in);
      #2;
      if (tick[2]) nt++;
      chk("t3_sq_hold", sq[2], sq_hold);
    end
    chk("t3_silent", nt, 32'd0);
    @(negedge clk_in);
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd3;
    #1;
    chk("t3_ready_dis", cfg_ready, 1'b1);
    @(posedge clk_in);
    acc = cyc;
    #2;
    cfg_valid = 1'b0;
    chk("t3_no_pend", pending[2], 1'b0);
    wait_tick(2, t);
    chk("t3_first", t - acc, 32'd3);
    chk("t3_sq_tog", sq[2], !sq_hold);

    // Test 4: ch3 written exactly on its wrap edge
    wait_tick(3, t);
    @(posedge clk_in);
    @(negedge clk_in);
    cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_div = 16'd7;
    @(posedge clk_in);
    acc = cyc;
    #2;
    cfg_valid = 1'b0;
    chk("t4_wrap_tick", tick[3], 1'b1);
    chk("t4_no_pend", pending[3], 1'b0);
    wait_tick(3, t2);
    chk("t4_gap", t2 - acc, 32'd7);

    // Test 5: run dropped for 10 edges with a write to ch0
    wait_tick(0, t);
    @(negedge clk_in);
    run = 1'b0;
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd4;
    nt = 0;
    @(posedge clk_in);
    #2;
    cfg_valid = 1'b0;
    chk("t5_pend_set", pending[0], 1'b1);
    if (tick != '0) nt++;
    repeat (9) begin
      @(posedge clk_in);
      #2;
      if (tick != '0) nt++;
    end
    chk("t5_no_ticks", nt, 32'd0);
    chk("t5_pend_held", pending[0], 1'b1);
    @(negedge clk_in);
    run = 1'b1;
    r = cyc + 1;
    wait_tick(0, t);
    chk("t5_resume", t - r, 32'd1);
    chk("t5_pend_clr", pending[0], 1'b0);
    wait_tick(0, t2);
    chk("t5_gap", t2 - t, 32'd4);

    // Test 6: out-of-range channel, then async reset with pending set
    @(negedge clk_in);
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 16'd3;
    #1;
    chk("t6_ready_oor", cfg_ready, 1'b1);
    @(posedge clk_in);
    #2;
    cfg_valid = 1'b0;
    chk("t6_err_hi", cfg_err, 1'b1);
    @(posedge clk_in);
    #2;
    chk("t6_err_lo", cfg_err, 1'b0);
    wait_tick(1, t);
    @(negedge clk_in);
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd9;
    @(posedge clk_in);
    #2;
    cfg_valid = 1'b0;
    chk("t6_pend_set", pending[1], 1'b1);
    @(posedge clk_in);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_pend", pending, '0);
    chk("t6_async_tick", tick, '0);
    chk("t6_async_sq", sq, '0);
    @(posedge clk_in);
    @(negedge clk_in) rst_n = 1'b1;
    reset_pattern("t6");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      rst_n     = ($urandom_range(0, 399) != 0);
      run       = ($urandom_range(0, 15) != 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = CH_W'($urandom_range(0, 7));
      cfg_div   = DIV_W'($urandom_range(0, 9));
    end
    @(negedge clk_in);
    cfg_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk_in);
    #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
